// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared opcode constants, forward-select encoding and issue FSM states.
package issue_hazard_ctrl_pkg;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] NOP_OP = 7'b0000000;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    function automatic logic writes_rd(input logic [6:0] opcode);
        return opcode inside {LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP};
    endfunction

endpackage

// File: rtl/issue_hazard_ctrl_hazard_detect.sv
// Operand forwarding selection and load-use detection for the ID instruction.
module hazard_detect
    import issue_hazard_ctrl_pkg::*;
#(
    parameter int RAW = 5
) (
    input  logic [6:0]     id_opcode,
    input  logic [RAW-1:0] id_rs1,
    input  logic [RAW-1:0] id_rs2,
    input  logic           ex_valid,
    input  logic [RAW-1:0] ex_rd,
    input  logic           ex_is_load,
    input  logic           m_valid,
    input  logic [RAW-1:0] m_rd,
    input  logic           m_is_load,
    output logic [1:0]     fwd1,
    output logic [1:0]     fwd2,
    output logic           load_use
);

    logic use1, use2;
    logic ex_hit1, ex_hit2, m_hit1, m_hit2;

    // Stage rd fields are already zeroed for non-writing entries.
    always_comb begin
        use1     = !(id_opcode inside {LUI, AUIPC, JAL});
        use2     = id_opcode inside {OP, STORE, BRANCH};
        ex_hit1  = use1 && ex_valid && (ex_rd != '0) && (id_rs1 == ex_rd);
        ex_hit2  = use2 && ex_valid && (ex_rd != '0) && (id_rs2 == ex_rd);
        m_hit1   = use1 && m_valid && m_is_load && (m_rd != '0) && (id_rs1 == m_rd);
        m_hit2   = use2 && m_valid && m_is_load && (m_rd != '0) && (id_rs2 == m_rd);
        fwd1     = ex_hit1 ? FWD_EX : (m_hit1 ? FWD_MEM : FWD_RF);
        fwd2     = ex_hit2 ? FWD_EX : (m_hit2 ? FWD_MEM : FWD_RF);
        load_use = ex_valid && ex_is_load && (ex_hit1 || ex_hit2);
    end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// ID/EX issue controller: registers the EX stage, forwards, stalls and flushes.
module issue_hazard_ctrl #(
    parameter int         XLEN   = 32,
    parameter int         RAW    = 5,
    parameter logic [6:0] NOP_OP = 7'b0000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic [19:0]     id_imm,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic [RAW-1:0]  id_rd,
    output logic [6:0]      dp_ctrl,
    output logic [2:0]      funct3,
    output logic [19:0]     immediate,
    output logic [XLEN-1:0] ex_pc,
    output logic [1:0]      forward_ctrl1,
    output logic [1:0]      forward_ctrl2,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] wr_pc,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_target,
    output logic [RAW-1:0]  wb_rd,
    output logic            wb_is_load
);

    import issue_hazard_ctrl_pkg::*;

    state_t         state, state_nx;
    logic           ex_valid, ex_is_load;
    logic [RAW-1:0] ex_rd;
    logic           m_valid, m_is_load;
    logic [RAW-1:0] m_rd;
    logic [1:0]     fwd1, fwd2;
    logic           load_use, redirect, issue;

    hazard_detect #(.RAW(RAW)) u_hazard (
        .id_opcode (id_opcode),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .ex_valid  (ex_valid),
        .ex_rd     (ex_rd),
        .ex_is_load(ex_is_load),
        .m_valid   (m_valid),
        .m_rd      (m_rd),
        .m_is_load (m_is_load),
        .fwd1      (fwd1),
        .fwd2      (fwd2),
        .load_use  (load_use)
    );

    // EX instruction redirects fetch: jumps always, branches only when taken.
    always_comb begin
        redirect = ex_valid && ((dp_ctrl == JAL) || (dp_ctrl == JALR) ||
                                ((dp_ctrl == BRANCH) && branch_taken));
    end

    // Issue FSM next state and decode handshake; redirect outranks load-use.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        id_ready = 1'b1;
        unique case (state)
            RUN: begin
                if (redirect) begin
                    state_nx = FLUSH;
                end else if (id_valid && load_use) begin
                    id_ready = 1'b0;
                    state_nx = STALL;
                end else begin
                    issue = id_valid;
                end
            end
            STALL: begin
                issue    = id_valid;
                state_nx = RUN;
            end
            FLUSH: begin
                state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    // EX/M/WB pipeline registers and registered fetch redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_ctrl       <= NOP_OP;
            funct3        <= '0;
            immediate     <= '0;
            ex_pc         <= '0;
            forward_ctrl1 <= FWD_RF;
            forward_ctrl2 <= FWD_RF;
            ex_valid      <= 1'b0;
            ex_rd         <= '0;
            ex_is_load    <= 1'b0;
            m_valid       <= 1'b0;
            m_rd          <= '0;
            m_is_load     <= 1'b0;
            wb_rd         <= '0;
            wb_is_load    <= 1'b0;
            pc_load       <= 1'b0;
            pc_target     <= '0;
        end else begin
            if (issue) begin
                dp_ctrl       <= id_opcode;
                funct3        <= id_funct3;
                immediate     <= id_imm;
                ex_pc         <= id_pc;
                forward_ctrl1 <= fwd1;
                forward_ctrl2 <= fwd2;
                ex_valid      <= 1'b1;
                ex_rd         <= writes_rd(id_opcode) ? id_rd : '0;
                ex_is_load    <= (id_opcode == LOAD);
            end else begin
                dp_ctrl       <= NOP_OP;
                funct3        <= '0;
                immediate     <= '0;
                ex_pc         <= '0;
                forward_ctrl1 <= FWD_RF;
                forward_ctrl2 <= FWD_RF;
                ex_valid      <= 1'b0;
                ex_rd         <= '0;
                ex_is_load    <= 1'b0;
            end
            m_valid    <= ex_valid;
            m_rd       <= ex_rd;
            m_is_load  <= ex_is_load;
            wb_rd      <= m_valid ? m_rd : '0;
            wb_is_load <= m_valid && m_is_load && (m_rd != '0);
            pc_load    <= redirect;
            if (redirect) pc_target <= wr_pc;
        end
    end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
module tb_issue_hazard_ctrl;

    localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JAL = 7'b1101111;
    localparam logic [6:0] O_JALR = 7'b1100111, O_BR = 7'b1100011, O_LD = 7'b0000011;
    localparam logic [6:0] O_ST = 7'b0100011, O_OPI = 7'b0010011, O_OP = 7'b0110011;
    localparam logic [6:0] O_NOP = 7'b0000000;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [19:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
    } instr_t;

    typedef struct {
        bit ready; bit valid;
        logic [6:0] op; logic [2:0] f3; logic [19:0] imm; logic [31:0] pc;
        logic [1:0] f1, f2;
        bit pcl; logic [31:0] pct;
        logic [4:0] wbrd; bit wbl;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        id_valid = 1'b0, id_ready;
    logic [6:0]  id_opcode = '0;
    logic [2:0]  id_funct3 = '0;
    logic [19:0] id_imm = '0;
    logic [31:0] id_pc = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [6:0]  dp_ctrl;
    logic [2:0]  funct3;
    logic [19:0] immediate;
    logic [31:0] ex_pc;
    logic [1:0]  forward_ctrl1, forward_ctrl2;
    logic        branch_taken = 1'b0;
    logic [31:0] wr_pc = '0;
    logic        pc_load;
    logic [31:0] pc_target;
    logic [4:0]  wb_rd;
    logic        wb_is_load;

    issue_hazard_ctrl #(.XLEN(32), .RAW(5), .NOP_OP(7'b0000000)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_imm(id_imm), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .dp_ctrl(dp_ctrl), .funct3(funct3), .immediate(immediate), .ex_pc(ex_pc),
        .forward_ctrl1(forward_ctrl1), .forward_ctrl2(forward_ctrl2),
        .branch_taken(branch_taken), .wr_pc(wr_pc), .pc_load(pc_load),
        .pc_target(pc_target), .wb_rd(wb_rd), .wb_is_load(wb_is_load)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0, passed = 0, cyc = 0;
    exp_t sb[$];

    // Reference model: pipeline contents as issued slots, plus count of slots still to squash.
    bit          md_ex_v, md_ex_ld; logic [6:0] md_ex_op; logic [2:0] md_ex_f3;
    logic [19:0] md_ex_imm; logic [31:0] md_ex_pc; logic [4:0] md_ex_rd; logic [1:0] md_ex_f1, md_ex_f2;
    bit          md_m_v, md_m_ld; logic [4:0] md_m_rd;
    logic [4:0]  md_wb_rd; bit md_wb_ld;
    bit          md_pcl; logic [31:0] md_pct;
    int          md_squash;
    logic [31:0] pc_ctr = 32'h1000;

    function automatic void model_reset();
        md_ex_v = 0; md_ex_ld = 0; md_ex_op = O_NOP; md_ex_f3 = '0; md_ex_imm = '0;
        md_ex_pc = '0; md_ex_rd = '0; md_ex_f1 = '0; md_ex_f2 = '0;
        md_m_v = 0; md_m_ld = 0; md_m_rd = '0; md_wb_rd = '0; md_wb_ld = 0;
        md_pcl = 0; md_pct = '0; md_squash = 0;
    endfunction

    // Where operand rs comes from: 1 = EX result, 2 = load data in M, 0 = register file.
    function automatic logic [1:0] src(input logic [4:0] rs);
        if (rs != 0 && md_ex_v && md_ex_rd == rs) return 2'd1;
        if (rs != 0 && md_m_v && md_m_ld && md_m_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    function automatic exp_t snapshot(input bit ready);
        exp_t e;
        e.ready = ready; e.valid = md_ex_v; e.op = md_ex_op; e.f3 = md_ex_f3; e.imm = md_ex_imm;
        e.pc = md_ex_pc; e.f1 = md_ex_f1; e.f2 = md_ex_f2; e.pcl = md_pcl; e.pct = md_pct;
        e.wbrd = md_wb_rd; e.wbl = md_wb_ld;
        return e;
    endfunction

    function automatic bit model_step(input bit v, input instr_t in, input bit bt, input logic [31:0] wpc);
        bit redirect, discard, bubble, take, u1, u2, writes;
        logic [1:0] s1, s2;
        redirect = md_ex_v && (md_ex_op == O_JAL || md_ex_op == O_JALR || (md_ex_op == O_BR && bt));
        u1 = !(in.op == O_LUI || in.op == O_AUIPC || in.op == O_JAL);
        u2 = (in.op == O_OP || in.op == O_ST || in.op == O_BR);
        s1 = u1 ? src(in.rs1) : 2'd0;
        s2 = u2 ? src(in.rs2) : 2'd0;
        discard = (md_squash > 0) || redirect;
        bubble  = v && !discard && md_ex_ld && (s1 == 2'd1 || s2 == 2'd1);
        take    = v && !discard && !bubble;
        sb.push_back(snapshot(!bubble));
        writes = (in.op inside {O_LUI, O_AUIPC, O_JAL, O_JALR, O_LD, O_OPI, O_OP});
        md_wb_rd = md_m_v ? md_m_rd : '0;
        md_wb_ld = md_m_v && md_m_ld && md_m_rd != 0;
        md_m_v = md_ex_v; md_m_rd = md_ex_rd; md_m_ld = md_ex_ld;
        md_ex_v   = take;
        md_ex_op  = take ? in.op : O_NOP;
        md_ex_f3  = take ? in.f3 : '0;
        md_ex_imm = take ? in.imm : '0;
        md_ex_pc  = take ? in.pc : '0;
        md_ex_rd  = (take && writes) ? in.rd : '0;
        md_ex_ld  = take && in.op == O_LD;
        md_ex_f1  = take ? s1 : 2'd0;
        md_ex_f2  = take ? s2 : 2'd0;
        md_pcl = redirect;
        if (redirect) md_pct = wpc;
        md_squash = redirect ? 1 : (md_squash > 0 ? md_squash - 1 : 0);
        return !bubble;
    endfunction

    task automatic cycle(input bit rst, input bit v, input instr_t in, input bit bt,
                         input logic [31:0] wpc, output bit acc);
        @(posedge clk); #1;
        cyc++;
        rst_n = !rst; id_valid = v; id_opcode = in.op; id_funct3 = in.f3; id_imm = in.imm;
        id_pc = in.pc; id_rd = in.rd; id_rs1 = in.rs1; id_rs2 = in.rs2;
        branch_taken = bt; wr_pc = wpc;
        if (rst) begin
            model_reset();
            sb.push_back(snapshot(1'b1));
            acc = 1'b0;
        end else begin
            acc = model_step(v, in, bt, wpc) && v;
        end
    endtask

    function automatic instr_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [19:0] imm);
        instr_t i;
        i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.f3 = imm[2:0]; i.pc = '0;
        return i;
    endfunction

    task automatic send(input instr_t in, input bit bt, input logic [31:0] wpc);
        bit acc = 1'b0;
        in.pc = pc_ctr;
        pc_ctr += 4;
        for (int t = 0; t < 4 && !acc; t++) cycle(1'b0, 1'b1, in, bt, wpc, acc);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, mk(O_NOP, 0, 0, 0, 0), 1'b0, 32'h0, acc);
    endtask

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endfunction

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("id_ready", 32'(id_ready), 32'(e.ready));
                chk("dp_ctrl", 32'(dp_ctrl), 32'(e.op));
                chk("forward_ctrl1", 32'(forward_ctrl1), 32'(e.f1));
                chk("forward_ctrl2", 32'(forward_ctrl2), 32'(e.f2));
                chk("pc_load", 32'(pc_load), 32'(e.pcl));
                chk("pc_target", pc_target, e.pct);
                chk("wb_rd", 32'(wb_rd), 32'(e.wbrd));
                chk("wb_is_load", 32'(wb_is_load), 32'(e.wbl));
                if (e.valid) begin
                    chk("funct3", 32'(funct3), 32'(e.f3));
                    chk("immediate", 32'(immediate), 32'(e.imm));
                    chk("ex_pc", ex_pc, e.pc);
                end
            end
        end
    end

    initial begin
        bit acc, have;
        instr_t cur;
        logic [6:0] ops [10];
        ops = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LD, O_ST, O_OPI, O_OP, O_NOP};
        model_reset();
        cycle(1'b1, 1'b0, mk(O_NOP, 0, 0, 0, 0), 1'b0, 32'h0, acc);
        cycle(1'b1, 1'b0, mk(O_NOP, 0, 0, 0, 0), 1'b0, 32'h0, acc);

        // Back-to-back EX forwarding on both operands.
        send(mk(O_OPI, 1, 0, 0, 20'd5), 0, 0);
        send(mk(O_OP, 2, 1, 1, 20'd0), 0, 0);
        idle(2);
        // Load-use: one bubble, then forward from M.
        send(mk(O_LD, 3, 0, 0, 20'd0), 0, 0);
        send(mk(O_OPI, 4, 3, 0, 20'd1), 0, 0);
        idle(3);
        // x0 never forwards.
        send(mk(O_OPI, 0, 0, 0, 20'd7), 0, 0);
        send(mk(O_OP, 5, 0, 0, 20'd0), 0, 0);
        idle(2);
        // Taken branch, then JALR with branch_taken low.
        send(mk(O_BR, 0, 1, 2, 20'd4), 0, 0);
        send(mk(O_OPI, 6, 1, 0, 20'd1), 1, 32'h100);
        send(mk(O_OPI, 7, 1, 0, 20'd2), 0, 0);
        send(mk(O_OPI, 8, 1, 0, 20'd3), 0, 0);
        idle(2);
        send(mk(O_JALR, 1, 2, 0, 20'd0), 0, 0);
        send(mk(O_OPI, 6, 1, 0, 20'd1), 0, 32'h200);
        send(mk(O_OPI, 7, 1, 0, 20'd2), 0, 0);
        send(mk(O_OPI, 8, 1, 0, 20'd3), 0, 0);
        idle(2);
        // Load, dependent taken branch, dependent instruction squashed by redirect.
        send(mk(O_LD, 3, 0, 0, 20'd8), 0, 0);
        send(mk(O_BR, 0, 3, 3, 20'd8), 0, 0);
        send(mk(O_OP, 7, 3, 0, 20'd0), 1, 32'h300);
        send(mk(O_OP, 9, 3, 0, 20'd0), 0, 0);
        send(mk(O_OP, 10, 3, 0, 20'd0), 0, 0);
        idle(2);
        // Asynchronous reset in the flush slot.
        send(mk(O_JAL, 1, 0, 0, 20'd16), 0, 0);
        cycle(1'b0, 1'b1, mk(O_OP, 2, 1, 1, 20'd0), 1'b0, 32'h400, acc);
        cycle(1'b1, 1'b1, mk(O_OP, 2, 1, 1, 20'd0), 1'b0, 32'h0, acc);
        cycle(1'b1, 1'b0, mk(O_NOP, 0, 0, 0, 0), 1'b0, 32'h0, acc);
        send(mk(O_OP, 5, 1, 2, 20'd0), 0, 0);
        idle(2);

        // Randomized traffic over a small register set to provoke hazards.
        have = 0;
        for (int n = 0; n < 600; n++) begin
            if (!have) begin
                have = ($urandom_range(0, 9) < 8);
                cur = mk(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 20'($urandom));
                cur.pc = $urandom;
            end
            cycle(1'b0, have, cur, 1'($urandom_range(0, 1)), $urandom, acc);
            if (acc) have = 0;
        end

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
